// File: rtl/nibble_serial_addsub.sv
// Serial WIDTH-bit adder/subtractor that handles one 4-bit nibble per clock, LSB nibble first.
// Each nibble uses lookahead carry equations. A registered carry links one nibble to the next.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic [3:0]       ak, bk, g, p, s;
    logic             c1, c2, c3, c4;

    // A new operation may begin from IDLE, or straight out of DONE for back-to-back use
    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(N - 1));

    // Operands shift right each step, so the current nibble is always in the low 4 bits
    assign ak = a_reg[3:0];
    assign bk = b_reg[3:0];
    assign g  = ak & bk;
    assign p  = ak ^ bk;
    assign c1 = g[0] | (p[0] & carry);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry);
    assign s  = p ^ {c3, c2, c1, carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = accept ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> 4;
            b_reg <= b_reg >> 4;
            carry <= c4;
            cnt   <= cnt + 1'b1;
            for (int k = 0; k < N; k++) begin
                if (cnt == CW'(k)) result[4*k +: 4] <= s;
            end
            if (last) begin
                cout <= c4;
                ovf  <= c4 ^ c3;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub at WIDTH=16.
module tb_nibble_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;

    nibble_serial_addsub #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Drives one start pulse and waits (bounded) for done; lat is in edges after the start edge
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0000", result); end
        checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {cout, ovf}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(16'h1234, 16'h0FCE, 1'b0, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 4", lat); end
        checks++; if (bc !== 4) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 4", bc); end
        checks++; if (result !== 16'h2202) begin errors++; $display("[TB] FAIL basic_result: got %h expected 2202", result); end
        checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("[TB] FAIL basic_flags: got %b expected 00", {cout, ovf}); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width: got %b expected 0", done); end
        checks++; if (result !== 16'h2202) begin errors++; $display("[TB] FAIL basic_hold: got %h expected 2202", result); end
    endtask

    task automatic test_add_ripple();
        int lat, bc;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL ripple_latency: got %0d expected 4", lat); end
        checks++; if (result !== 16'h0000) begin errors++; $display("[TB] FAIL ripple_result: got %h expected 0000", result); end
        checks++; if ({cout, ovf} !== 2'b10) begin errors++; $display("[TB] FAIL ripple_flags: got %b expected 10", {cout, ovf}); end
        run_op(16'h7FFF, 16'h0001, 1'b0, lat, bc);
        checks++; if (result !== 16'h8000) begin errors++; $display("[TB] FAIL addovf_result: got %h expected 8000", result); end
        checks++; if ({cout, ovf} !== 2'b01) begin errors++; $display("[TB] FAIL addovf_flags: got %b expected 01", {cout, ovf}); end
    endtask

    task automatic test_sub();
        int lat, bc;
        run_op(16'h0005, 16'h0007, 1'b1, lat, bc);
        checks++; if (result !== 16'hFFFE) begin errors++; $display("[TB] FAIL sub_borrow_result: got %h expected fffe", result); end
        checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("[TB] FAIL sub_borrow_flags: got %b expected 00", {cout, ovf}); end
        run_op(16'h8000, 16'h0001, 1'b1, lat, bc);
        checks++; if (result !== 16'h7FFF) begin errors++; $display("[TB] FAIL sub_ovf_result: got %h expected 7fff", result); end
        checks++; if ({cout, ovf} !== 2'b11) begin errors++; $display("[TB] FAIL sub_ovf_flags: got %b expected 11", {cout, ovf}); end
        run_op(16'h1234, 16'h0000, 1'b1, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL sub_zero_latency: got %0d expected 4", lat); end
        checks++; if (result !== 16'h1234) begin errors++; $display("[TB] FAIL sub_zero_result: got %h expected 1234", result); end
        checks++; if ({cout, ovf} !== 2'b10) begin errors++; $display("[TB] FAIL sub_zero_flags: got %b expected 10", {cout, ovf}); end
    endtask

    task automatic test_start_while_busy();
        int          done_cnt = 0;
        logic [15:0] res_cap = 16'hDEAD;
        logic [1:0]  flag_cap = 2'b11;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hAAAA; b = 16'h5555;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin res_cap = result; flag_cap = {cout, ovf}; end
            end
            @(negedge clk);
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
        checks++; if (res_cap !== 16'h0002) begin errors++; $display("[TB] FAIL busy_start_result: got %h expected 0002", res_cap); end
        checks++; if (flag_cap !== 2'b00) begin errors++; $display("[TB] FAIL busy_start_flags: got %b expected 00", flag_cap); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(16'h1111, 16'h2222, 1'b0, lat, bc);
        checks++; if (result !== 16'h3333) begin errors++; $display("[TB] FAIL b2b_first_result: got %h expected 3333", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_busy: got %b expected 0", busy); end
        a = 16'h00F0; b = 16'h0010; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_busy: got %b expected 1", busy); end
        lat = 0;
        bc = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 4", lat); end
        checks++; if (bc !== 4) begin errors++; $display("[TB] FAIL b2b_busy_cycles: got %0d expected 4", bc); end
        checks++; if (result !== 16'h00E0) begin errors++; $display("[TB] FAIL b2b_result: got %h expected 00e0", result); end
        checks++; if ({cout, ovf} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_flags: got %b expected 10", {cout, ovf}); end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        int done_cnt = 0;
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_result: got %h expected 0000", result); end
        checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_flags: got %b expected 00", {cout, ovf}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL midrst_activity: got %0d expected 0", done_cnt); end
        run_op(16'h00FF, 16'h0001, 1'b0, lat, bc);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL postrst_latency: got %0d expected 4", lat); end
        checks++; if (result !== 16'h0100) begin errors++; $display("[TB] FAIL postrst_result: got %h expected 0100", result); end
        checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("[TB] FAIL postrst_flags: got %b expected 00", {cout, ovf}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_add_ripple();
        test_sub();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that consumes one 4-bit nibble per clock, LSB nibble first.
- Each nibble uses 4-bit lookahead carry equations, and a registered carry links consecutive nibbles.
- It is the sequential, subtract-capable counterpart of the combinational lookahead carry unit. It serves area-constrained datapaths that accept WIDTH/4 cycles of latency.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and ≥ 8. N = WIDTH/4 nibble steps.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result/cout/ovf are valid
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- cout  output  1  carry out of MSB. For subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset is asynchronous, active-low, and applies at any time, including mid-operation.
  - busy, done, result, cout and ovf go to 0.
  - The FSM goes to IDLE. Operand registers, carry register and nibble counter clear.
  - An operation in flight is discarded; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Latch a.
  - Latch b, or ~b if sub=1.
  - Carry register ← sub.
  - Counter ← 0. Go to RUN; busy=1 after E0.
- RUN, one edge per nibble k = 0..N−1:
  - Inputs: ak = a[4k+3:4k], bk = latched b nibble, c = carry register.
  - gi = ak[i] & bk[i]; pi = ak[i] ^ bk[i].
  - c1..c4 follow the lookahead equations: c(i+1) = gi | (pi & ci), with c0 = c.
  - Sum bit si = pi ^ ci. Write the 4 sum bits to result[4k+3:4k].
  - Carry register ← c4.
  - On k = N−1 (edge EN):
    - cout ← c4.
    - ovf ← c4 ^ c3 (carry into MSB xor carry out of MSB).
    - Go to DONE.
- Timing and handshake:
  - After EN: busy=0 and done=1 for exactly one cycle (the DONE state). Latency start→done = N cycles.
  - DONE → IDLE on the next edge. If start=1 in the DONE cycle, it is accepted as a new E0 (back-to-back; IDLE is skipped).
  - start is ignored while busy=1. Operand changes on a, b or sub during busy have no effect.
- Output stability:
  - result/cout/ovf are final from the DONE cycle onward.
  - They hold until the next accepted start.
  - During RUN, result holds partially updated nibbles and must not be consumed.
- Arithmetic:
  - All unsigned modulo 2^WIDTH; carry out of nibble N−1 is never wrapped into nibble 0.
  - Subtract is computed as a + ~b + 1.
  - sub=1 with b=0 gives result=a, cout=1, ovf=0.

Test Plan:
- WIDTH=16: start with a=0x1234, b=0x0FCE, sub=0 → done exactly 4 cycles after start edge, one cycle wide; result=0x2202, cout=0, ovf=0. busy high for 4 cycles.
- Full carry ripple across all nibbles: a=0xFFFF, b=0x0001, sub=0 → result=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, sub=0 → result=0x8000, cout=0, ovf=1.
- Subtract with borrow, and subtract overflow:
  - a=0x0005, b=0x0007, sub=1 → result=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → result=0x7FFF, cout=1, ovf=1.
  - a=0x1234, b=0x0000, sub=1 → result=0x1234, cout=1, ovf=0.
- Start while busy:
  - Start a=0x0001, b=0x0001, sub=0.
  - Pulse start with a=0xFFFF, b=0xFFFF, sub=1 two cycles later, and change a, b.
  - Expect a single done with result=0x0002, cout=0, ovf=0.
- Back-to-back:
  - start held in the DONE cycle with a=0x00F0, b=0x0010, sub=1.
  - Expect the first done, then second done N cycles later with result=0x00E0, cout=1. busy=0 only during the DONE cycle.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously (between clock edges) after 2 RUN cycles.
  - Outputs go to 0 immediately and no done follows.
  - After release, a fresh a=0x00FF, b=0x0001, sub=0 gives result=0x0100, cout=0, ovf=0.
